// File: rtl/rtc_read_seq_pkg.sv
// Shared definitions for the RTC read sequencer and the per-register edit modules:
// FSM state encoding, RTC register addresses, strobe indices and the bus drive payload.
// Build option: RTC_READ_TIMER_EN appends the three timer registers to the scan.
package rtc_read_seq_pkg;

  localparam int unsigned IDX_W    = 4;
  localparam int unsigned STROBE_W = 9;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned PERIOD_W = 20;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_END = 3'd2,
    READ     = 3'd3,
    CAPTURE  = 3'd4,
    RECOVER  = 3'd5
  } state_e;

  // Strobe indices, shared with the edit modules
  localparam int unsigned IDX_SEC  = 0;
  localparam int unsigned IDX_MIN  = 1;
  localparam int unsigned IDX_HOUR = 2;
  localparam int unsigned IDX_DAY  = 3;
  localparam int unsigned IDX_MON  = 4;
  localparam int unsigned IDX_YEAR = 5;
  localparam int unsigned IDX_TMR0 = 6;
  localparam int unsigned IDX_TMR1 = 7;
  localparam int unsigned IDX_TMR2 = 8;

  // RTC register addresses
  localparam logic [DATA_W-1:0] ADDR_SEC  = 8'h21;
  localparam logic [DATA_W-1:0] ADDR_MIN  = 8'h22;
  localparam logic [DATA_W-1:0] ADDR_HOUR = 8'h23;
  localparam logic [DATA_W-1:0] ADDR_DAY  = 8'h24;
  localparam logic [DATA_W-1:0] ADDR_MON  = 8'h25;
  localparam logic [DATA_W-1:0] ADDR_YEAR = 8'h26;
  localparam logic [DATA_W-1:0] ADDR_TMR0 = 8'h41;
  localparam logic [DATA_W-1:0] ADDR_TMR1 = 8'h42;
  localparam logic [DATA_W-1:0] ADDR_TMR2 = 8'h43;

`ifdef RTC_READ_TIMER_EN
  localparam int unsigned           NUM_REGS    = 9;
  localparam logic [STROBE_W-1:0]   STROBE_MASK = 9'h1FF;
`else
  localparam int unsigned           NUM_REGS    = 6;
  localparam logic [STROBE_W-1:0]   STROBE_MASK = 9'h03F;
`endif

  // Registered drive of the RTC bus pins
  typedef struct packed {
    logic              cs_n;
    logic              rd_n;
    logic              ad_oe;
    logic              ad_sel;
    logic [DATA_W-1:0] ad_out;
  } rtc_bus_t;

  localparam rtc_bus_t BUS_IDLE = '{cs_n: 1'b1, rd_n: 1'b1, ad_oe: 1'b0, ad_sel: 1'b0, ad_out: 8'h00};

  // Scan position to RTC register address
  function automatic logic [DATA_W-1:0] reg_addr(input logic [IDX_W-1:0] idx);
    logic [DATA_W-1:0] a;
    case (idx)
      IDX_W'(IDX_SEC):  a = ADDR_SEC;
      IDX_W'(IDX_MIN):  a = ADDR_MIN;
      IDX_W'(IDX_HOUR): a = ADDR_HOUR;
      IDX_W'(IDX_DAY):  a = ADDR_DAY;
      IDX_W'(IDX_MON):  a = ADDR_MON;
      IDX_W'(IDX_YEAR): a = ADDR_YEAR;
      IDX_W'(IDX_TMR0): a = ADDR_TMR0;
      IDX_W'(IDX_TMR1): a = ADDR_TMR1;
      IDX_W'(IDX_TMR2): a = ADDR_TMR2;
      default:          a = ADDR_SEC;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/rtc_read_seq_phase_timer.sv
// rtc_phase_timer: loadable down-counter timing one bus phase.
// Ports: clk, reset (sync, active-high), load/load_val start a phase,
//        done_c is high in the last cycle of the loaded phase (once per load).
module rtc_phase_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done_c
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             active_q, active_d;

  // Load wins over counting; the counter parks at zero once the phase ends
  always_comb begin
    count_d  = count_q;
    active_d = active_q;
    if (load) begin
      count_d  = load_val;
      active_d = 1'b1;
    end else if (active_q) begin
      if (count_q == '0) begin
        active_d = 1'b0;
      end else begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      active_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      active_q <= active_d;
    end
  end

  assign done_c = active_q && (count_q == '0);

endmodule

// File: rtl/rtc_read_seq.sv
// rtc_read_seq: periodically reads the RTC time registers over a multiplexed
// address/data bus and strobes each captured BCD byte to the display logic.
// Ports: CLK, RESET (sync, active-high), Modificando (edit in progress, holds off scans),
//        AD_in/AD_out/AD_OE (bus data), CS_n/RD_n/WR_n/AD_sel (bus control),
//        DATA_out (last captured byte), Actualizar (one-hot update strobe), BUSY.
// Build option: RTC_READ_TIMER_EN adds timer registers 0x41..0x43 (strobes 6..8).
module rtc_read_seq
  import rtc_read_seq_pkg::*;
#(
  parameter int unsigned T_PHASE     = 10,
  parameter int unsigned SCAN_PERIOD = 1000000
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                Modificando,
  input  logic [DATA_W-1:0]   AD_in,
  output logic [DATA_W-1:0]   AD_out,
  output logic                AD_OE,
  output logic                CS_n,
  output logic                RD_n,
  output logic                WR_n,
  output logic                AD_sel,
  output logic [DATA_W-1:0]   DATA_out,
  output logic [STROBE_W-1:0] Actualizar,
  output logic                BUSY
);

  localparam logic [PERIOD_W-1:0] PERIOD_LAST = PERIOD_W'(SCAN_PERIOD - 1);
  localparam logic [7:0]          PHASE_LOAD  = 8'(T_PHASE - 1);
  localparam logic [IDX_W-1:0]    IDX_LAST    = IDX_W'(NUM_REGS - 1);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [PERIOD_W-1:0]  period_q, period_d;
  logic                 pending_q, pending_d;
  logic                 abort_q, abort_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic [STROBE_W-1:0]  act_q, act_d;
  logic                 busy_q, busy_d;
  rtc_bus_t             bus_q, bus_d;

  logic                 period_hit_c;
  logic                 start_c;
  logic                 timer_load_c;
  logic                 timer_done_c;

  rtc_phase_timer #(
    .CNT_W (8)
  ) u_phase_timer (
    .clk      (CLK),
    .reset    (RESET),
    .load     (timer_load_c),
    .load_val (PHASE_LOAD),
    .done_c   (timer_done_c)
  );

  assign period_hit_c = (period_q == PERIOD_LAST);
  // A missed period start (edit in progress) is remembered and taken on release
  assign start_c      = (state_q == IDLE) && !Modificando && (period_hit_c || pending_q);

  // Next state, sequencing and registered output decode (outputs follow state_d)
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    timer_load_c = 1'b0;
    period_d     = period_hit_c ? '0 : period_q + PERIOD_W'(1);
    pending_d    = pending_q;
    abort_d      = abort_q | (Modificando && (state_q != IDLE));
    data_d       = data_q;
    act_d        = '0;
    bus_d        = BUS_IDLE;

    if (start_c) begin
      pending_d = 1'b0;
    end else if (period_hit_c && Modificando) begin
      pending_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start_c) begin
          state_d      = ADDR;
          idx_d        = '0;
          timer_load_c = 1'b1;
        end
      end
      ADDR: begin
        if (timer_done_c) begin
          state_d      = ADDR_END;
          timer_load_c = 1'b1;
        end
      end
      ADDR_END: begin
        if (timer_done_c) begin
          state_d      = READ;
          timer_load_c = 1'b1;
        end
      end
      READ: begin
        if (timer_done_c) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        state_d      = RECOVER;
        timer_load_c = 1'b1;
      end
      RECOVER: begin
        if (timer_done_c) begin
          // An edit seen anywhere in this scan ends it after the current transaction
          if (abort_d || (idx_q == IDX_LAST)) begin
            state_d = IDLE;
          end else begin
            state_d      = ADDR;
            idx_d        = idx_q + IDX_W'(1);
            timer_load_c = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d == IDLE) begin
      abort_d = 1'b0;
    end

    busy_d = (state_d != IDLE);

    // Bus phases; AD_OE and RD_n=0 never share a state, so they cannot overlap
    case (state_d)
      ADDR: begin
        bus_d.cs_n   = 1'b0;
        bus_d.ad_oe  = 1'b1;
        bus_d.ad_out = reg_addr(idx_d);
      end
      ADDR_END: begin
        bus_d.ad_oe  = 1'b1;
        bus_d.ad_out = reg_addr(idx_d);
      end
      READ: begin
        bus_d.cs_n   = 1'b0;
        bus_d.rd_n   = 1'b0;
        bus_d.ad_sel = 1'b1;
      end
      CAPTURE: begin
        bus_d.cs_n   = 1'b0;
        bus_d.rd_n   = 1'b0;
        bus_d.ad_sel = 1'b1;
        data_d       = AD_in;
        act_d        = STROBE_W'(1) << idx_q;
      end
      default: begin
        bus_d = BUS_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      period_q  <= '0;
      pending_q <= 1'b0;
      abort_q   <= 1'b0;
      data_q    <= '0;
      act_q     <= '0;
      busy_q    <= 1'b0;
      bus_q     <= BUS_IDLE;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      period_q  <= period_d;
      pending_q <= pending_d;
      abort_q   <= abort_d;
      data_q    <= data_d;
      act_q     <= act_d;
      busy_q    <= busy_d;
      bus_q     <= bus_d;
    end
  end

  assign AD_out     = bus_q.ad_out;
  assign AD_OE      = bus_q.ad_oe;
  assign CS_n       = bus_q.cs_n;
  assign RD_n       = bus_q.rd_n;
  assign AD_sel     = bus_q.ad_sel;
  assign WR_n       = 1'b1;
  assign DATA_out   = data_q;
  // Strobes beyond the configured scan length are tied low
  assign Actualizar = act_q & STROBE_MASK;
  assign BUSY       = busy_q;

endmodule

// File: tb/tb_rtc_read_seq.sv
// Directed bench for rtc_read_seq with a small RTC bus model.
module tb_rtc_read_seq;

  localparam int unsigned T_PHASE = 2;
  localparam int unsigned SP      = 200;
`ifdef RTC_READ_TIMER_EN
  localparam int NREG = 9;
`else
  localparam int NREG = 6;
`endif

  logic       CLK;
  logic       RESET;
  logic       Modificando;
  logic [7:0] AD_in;
  logic [7:0] AD_out;
  logic       AD_OE;
  logic       CS_n;
  logic       RD_n;
  logic       WR_n;
  logic       AD_sel;
  logic [7:0] DATA_out;
  logic [8:0] Actualizar;
  logic       BUSY;

  rtc_read_seq #(
    .T_PHASE     (T_PHASE),
    .SCAN_PERIOD (SP)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .Modificando (Modificando),
    .AD_in       (AD_in),
    .AD_out      (AD_out),
    .AD_OE       (AD_OE),
    .CS_n        (CS_n),
    .RD_n        (RD_n),
    .WR_n        (WR_n),
    .AD_sel      (AD_sel),
    .DATA_out    (DATA_out),
    .Actualizar  (Actualizar),
    .BUSY        (BUSY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Hand-computed scan contents in strobe order
  logic [7:0] exp_data [9] = '{8'h59, 8'h30, 8'h12, 8'h15, 8'h08, 8'h24, 8'h11, 8'h22, 8'h33};
  logic [7:0] exp_addr [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};

  // RTC model: returns a fixed byte for the last latched address
  logic [7:0] cur_addr = 8'h00;
  function automatic logic [7:0] rtc_data(input logic [7:0] a);
    case (a)
      8'h21: return 8'h59;
      8'h22: return 8'h30;
      8'h23: return 8'h12;
      8'h24: return 8'h15;
      8'h25: return 8'h08;
      8'h26: return 8'h24;
      8'h41: return 8'h11;
      8'h42: return 8'h22;
      8'h43: return 8'h33;
      default: return 8'hEE;
    endcase
  endfunction
  assign AD_in = rtc_data(cur_addr);

  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Monitor state
  int         q_idx[$];
  logic [7:0] q_data[$];
  logic [7:0] q_addr[$];
  int         strobe_cyc = 0;
  int         viol_oe_rd = 0;
  int         viol_multi = 0;
  int         viol_outside = 0;
  int         viol_hi = 0;
  int         viol_wr = 0;
  int         good_runs = 0;
  int         bad_runs = 0;
  int         run_len [4] = '{0, 0, 0, 0};
  int         run_exp [4] = '{T_PHASE, T_PHASE, T_PHASE + 1, T_PHASE};

  always @(negedge CLK) begin
    logic [3:0] cls;
    int         idx;
    if (RESET) begin
      for (int k = 0; k < 4; k++) run_len[k] = 0;
    end else begin
      if (AD_OE && !RD_n) viol_oe_rd++;
      if ($countones(Actualizar) > 1) viol_multi++;
      if ((Actualizar != 9'd0) && RD_n) viol_outside++;
      if (Actualizar[8:6] != 3'd0) viol_hi++;
      if (!WR_n) viol_wr++;
      if (!CS_n && !AD_sel && AD_OE) cur_addr = AD_out;
      if (Actualizar != 9'd0) begin
        idx = -1;
        for (int i = 0; i < 9; i++) if (Actualizar[i]) idx = i;
        q_idx.push_back(idx);
        q_data.push_back(DATA_out);
        q_addr.push_back(cur_addr);
        strobe_cyc = cyc;
      end
      // Phase classes: ADDR, ADDR_END, READ+CAPTURE, RECOVER
      cls[0] = !CS_n && AD_OE;
      cls[1] = CS_n && AD_OE;
      cls[2] = !RD_n;
      cls[3] = BUSY && CS_n && RD_n && !AD_OE;
      for (int k = 0; k < 4; k++) begin
        if (cls[k]) begin
          run_len[k]++;
        end else if (run_len[k] != 0) begin
          if (run_len[k] == run_exp[k]) good_runs++;
          else bad_runs++;
          run_len[k] = 0;
        end
      end
    end
  end

  task automatic clear_q();
    q_idx.delete();
    q_data.delete();
    q_addr.delete();
  endtask

  task automatic wait_busy(input logic val, input int budget, input string tag);
    int n = 0;
    while (BUSY !== val && n < budget) begin
      @(posedge CLK); #1;
      n++;
    end
    chk(tag, 32'(BUSY), 32'(val));
  endtask

  task automatic wait_read(input logic [7:0] a, input string tag);
    int n = 0;
    while (!(RD_n == 1'b0 && Actualizar == 9'd0 && cur_addr == a) && n < 300) begin
      @(posedge CLK); #1;
      n++;
    end
    chk(tag, 32'({RD_n, (Actualizar == 9'd0), cur_addr}), 32'({1'b0, 1'b1, a}));
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ad_oe"},  32'(AD_OE),      32'h0);
    chk({tag, "_ad_out"}, 32'(AD_out),     32'h00);
    chk({tag, "_cs_n"},   32'(CS_n),       32'h1);
    chk({tag, "_rd_n"},   32'(RD_n),       32'h1);
    chk({tag, "_wr_n"},   32'(WR_n),       32'h1);
    chk({tag, "_ad_sel"}, 32'(AD_sel),     32'h0);
    chk({tag, "_data"},   32'(DATA_out),   32'h00);
    chk({tag, "_act"},    32'(Actualizar), 32'h000);
    chk({tag, "_busy"},   32'(BUSY),       32'h0);
  endtask

  task automatic chk_scan(input string tag);
    chk({tag, "_count"}, 32'(q_idx.size()), 32'(NREG));
    for (int i = 0; i < NREG; i++) begin
      if (i < q_idx.size()) begin
        chk($sformatf("%s_idx%0d", tag, i),  32'(q_idx[i]),  32'(i));
        chk($sformatf("%s_data%0d", tag, i), 32'(q_data[i]), 32'(exp_data[i]));
        chk($sformatf("%s_addr%0d", tag, i), 32'(q_addr[i]), 32'(exp_addr[i]));
      end
    end
  endtask

  initial begin
    int e0;
    int s3;
    RESET       = 1'b1;
    Modificando = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk_reset_outs("rst");
    e0    = cyc;
    RESET = 1'b0;

    // First scan starts SCAN_PERIOD cycles after the last reset edge
    wait_busy(1'b1, 2 * SP, "first_start");
    chk("first_start_cyc", 32'(cyc), 32'(e0 + SP));
    wait_busy(1'b0, 200, "first_end");
    @(negedge CLK); #1;
    chk_scan("scan1");
    chk("scan1_good_runs", 32'(good_runs), 32'(4 * NREG));

    // Edit raised during the hours read: hours completes, scan stops
    clear_q();
    wait_busy(1'b1, 2 * SP, "mod_start");
    s3 = cyc;
    wait_read(8'h23, "mod_hours_read");
    Modificando = 1'b1;
    wait_busy(1'b0, 100, "mod_end");
    chk("mod_fall_delay", 32'(cyc - strobe_cyc), 32'(T_PHASE + 1));
    @(negedge CLK); #1;
    chk("mod_count", 32'(q_idx.size()), 32'd3);
    if (q_idx.size() > 0) chk("mod_last_idx", 32'(q_idx[q_idx.size() - 1]), 32'd2);

    // Edit held across the period boundary, released 50 cycles later
    clear_q();
    while (cyc < s3 + int'(SP) + 49) begin
      @(posedge CLK); #1;
    end
    chk("defer_hold_busy", 32'(BUSY), 32'h0);
    Modificando = 1'b0;
    wait_busy(1'b1, 10, "defer_start");
    chk("defer_start_cyc", 32'(cyc), 32'(s3 + int'(SP) + 50));
    wait_busy(1'b0, 200, "defer_end");
    @(negedge CLK); #1;
    chk_scan("scan2");

    // Reset during the minutes read: no minutes strobe, outputs at reset values
    clear_q();
    wait_busy(1'b1, 2 * SP, "rst_scan_start");
    wait_read(8'h22, "rst_min_read");
    RESET = 1'b1;
    @(posedge CLK); #1;
    chk_reset_outs("midrst");
    chk("midrst_count", 32'(q_idx.size()), 32'd1);
    RESET = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    chk("post_rst_busy", 32'(BUSY), 32'h0);

    chk("viol_oe_rd",   32'(viol_oe_rd),   32'd0);
    chk("viol_multi",   32'(viol_multi),   32'd0);
    chk("viol_outside", 32'(viol_outside), 32'd0);
    chk("viol_wr",      32'(viol_wr),      32'd0);
    chk("bad_runs",     32'(bad_runs),     32'd0);
`ifndef RTC_READ_TIMER_EN
    chk("viol_hi_bits", 32'(viol_hi),      32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
